// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        WRITE,
        DZERO
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    // HI/LO source-mux select encoding
    localparam logic HILO_SRC_DIV  = 1'b0;
    localparam logic HILO_SRC_MULT = 1'b1;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Down-counter that times the multicycle unit; saturates at zero so it can never wrap.
module muldiv_cycle_counter
    import muldiv_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the MULT/DIV units and the HI/LO write enables.
// Outputs are registered from the next state, so every enable is a clean flop output.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        div_req,
    input  logic        abort,
    input  logic [31:0] b_operand,
    output logic        mult_start,
    output logic        div_start,
    output logic        hilo_src,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    // RUN lasts exactly N cycles: loaded with N-1, leaves when the count reads zero.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   hilo_src_q, hilo_src_d;

    logic   mult_start_q, div_start_q;
    logic   hi_write_q, lo_write_q, done_q;
    logic   busy_q, div_zero_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             cnt_zero;

    assign cnt_load       = (state_q == START);
    assign cnt_load_value = (op_q == OP_MULT) ? MULT_LOAD : DIV_LOAD;
    assign cnt_dec        = (state_q == RUN);

    muldiv_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk          (clk),
        .reset        (reset),
        .load_i       (cnt_load),
        .load_value_i (cnt_load_value),
        .dec_i        (cnt_dec),
        .zero_o       (cnt_zero)
    );

    // Next-state logic: requests are only looked at in IDLE, mult wins over div.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hilo_src_d = hilo_src_q;
        unique case (state_q)
            IDLE: begin
                if (mult_req) begin
                    state_d    = START;
                    op_d       = OP_MULT;
                    hilo_src_d = HILO_SRC_MULT;
                end else if (div_req) begin
                    if (b_operand == '0) begin
                        state_d = DZERO;
                    end else begin
                        state_d    = START;
                        op_d       = OP_DIV;
                        hilo_src_d = HILO_SRC_DIV;
                    end
                end
            end
            START: state_d = abort ? IDLE : RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d = WRITE;
                end
            end
            // a flush arriving in WRITE is too late to cancel the HI/LO update
            WRITE:   state_d = IDLE;
            DZERO:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, all cleared asynchronously so no write survives reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= OP_MULT;
            hilo_src_q   <= HILO_SRC_DIV;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            hi_write_q   <= 1'b0;
            lo_write_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            hilo_src_q   <= hilo_src_d;
            mult_start_q <= (state_d == START) && (op_d == OP_MULT);
            div_start_q  <= (state_d == START) && (op_d == OP_DIV);
            hi_write_q   <= (state_d == WRITE);
            lo_write_q   <= (state_d == WRITE);
            done_q       <= (state_d == WRITE);
            busy_q       <= (state_d != IDLE);
            div_zero_q   <= (state_d == DZERO);
        end
    end

    assign mult_start = mult_start_q;
    assign div_start  = div_start_q;
    assign hilo_src   = hilo_src_q;
    assign hi_write   = hi_write_q;
    assign lo_write   = lo_write_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a per-cycle vector table plus full-length sequences.
module tb_muldiv_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_req, div_req, abort;
    logic [31:0] b_operand;
    logic        mult_start, div_start, hilo_src, hi_write, lo_write, busy, done, div_zero;
    logic [7:0]  outv;

    int checks   = 0;
    int failures = 0;

    // {mult_start, div_start, hilo_src, hi_write, lo_write, busy, done, div_zero}
    assign outv = {mult_start, div_start, hilo_src, hi_write, lo_write, busy, done, div_zero};

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MULT_CYCLES (N),
        .DIV_CYCLES  (N),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_req   (mult_req),
        .div_req    (div_req),
        .abort      (abort),
        .b_operand  (b_operand),
        .mult_start (mult_start),
        .div_start  (div_start),
        .hilo_src   (hilo_src),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    typedef struct {
        logic        m;
        logic        d;
        logic        ab;
        logic [31:0] b;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int c, input logic [7:0] exp);
        checks++;
        if (outv !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, c, outv, exp);
        end
    endtask

    // Request issued in the current cycle (cycle 0); checks cycles 1..ncyc.
    // ign: cycle at which both requests are pulsed again (-1 none); a: abort cycle (-1 none).
    task automatic run_seq(input string name, input logic m, input logic d, input logic [31:0] b,
                           input int ign, input int a, input int ncyc, input logic exp_mult);
        logic       aborted;
        int         last;
        logic       wr;
        logic [7:0] exp;
        aborted   = (a >= 1) && (a <= N + 1);
        last      = aborted ? a : N + 2;
        mult_req  = m;
        div_req   = d;
        b_operand = b;
        abort     = (a == 0);
        for (int c = 1; c <= ncyc; c++) begin
            step();
            wr  = !aborted && (c == N + 2);
            exp = {exp_mult && (c == 1), !exp_mult && (c == 1), exp_mult,
                   wr, wr, (c <= last), wr, 1'b0};
            check(name, c, exp);
            mult_req = (c == ign);
            div_req  = (c == ign);
            abort    = (c == a);
        end
        mult_req = 1'b0;
        div_req  = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        //        m     d     ab    b       {ms ds hs hw lw bsy dn dz}
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0, 8'b00000101}; // div by zero -> DZERO
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'b00000000}; // back to idle
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'd0, 8'b00000000}; // abort in idle: no effect
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd7, 8'b10100100}; // both: mult wins
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd3, 8'b00100100}; // req in START ignored
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'd3, 8'b00100100}; // RUN
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'd3, 8'b00100000}; // abort in RUN
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'd3, 8'b00100000}; // hilo_src held
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd0, 8'b00100101}; // DZERO keeps hilo_src
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 8'b00100000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'd3, 8'b01000100}; // div start, hilo_src -> 0
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd3, 8'b00000000}; // abort in START

        reset     = 1'b0;
        mult_req  = 1'b0;
        div_req   = 1'b0;
        abort     = 1'b0;
        b_operand = 32'd0;
        step();
        check("reset_state", 0, 8'b0);
        step();
        #2 reset = 1'b1;
        step();
        check("post_reset_idle", 0, 8'b0);

        for (int i = 0; i < 12; i++) begin
            mult_req  = tbl[i].m;
            div_req   = tbl[i].d;
            abort     = tbl[i].ab;
            b_operand = tbl[i].b;
            step();
            check($sformatf("vec%0d", i), i, tbl[i].exp);
        end
        mult_req = 1'b0;
        div_req  = 1'b0;
        abort    = 1'b0;
        step();

        run_seq("mult_full",   1'b1, 1'b0, 32'd5, -1, -1, 38, 1'b1);
        run_seq("both_req",    1'b1, 1'b1, 32'd7, -1, -1, 38, 1'b1);
        run_seq("div_ignore",  1'b0, 1'b1, 32'd3, 10, -1, 40, 1'b0);
        run_seq("div_abort",   1'b0, 1'b1, 32'd3, -1, 20, 21, 1'b0);
        step();
        run_seq("mult_after",  1'b1, 1'b0, 32'd3, -1, -1, 38, 1'b1);
        run_seq("abort_idle",  1'b0, 1'b1, 32'd4, -1, 0, 36, 1'b0);
        run_seq("abort_write", 1'b1, 1'b0, 32'd9, -1, 34, 38, 1'b1);

        // asynchronous reset in the middle of a RUN
        mult_req  = 1'b1;
        b_operand = 32'd5;
        step();
        mult_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        #2 reset = 1'b0;
        #1 check("rst_async", 0, 8'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("rst_hold", k, 8'b0);
        end
        #2 reset = 1'b1;
        step();
        check("rst_release", 0, 8'b0);
        run_seq("div_post_rst", 1'b0, 1'b1, 32'd2, -1, -1, 36, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
